// File: rtl/lsu_pkg.sv
// lsu_pkg: shared FSM states, RV32I width codes and byte-count helper for the load/store unit
package lsu_pkg;
  typedef enum logic [2:0] {IDLE, ST_BYTE, LD_ISSUE, LD_CAP, DONE} state_t;
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;
  function automatic logic [2:0] byte_count(input logic [2:0] funct3);
    return funct3[1] ? 3'd4 : funct3[0] ? 3'd2 : 3'd1;
  endfunction
endpackage

// File: rtl/lsu_load_extend.sv
// lsu_load_extend: sign/zero extension of an assembled load value by its width code
module lsu_load_extend
  import lsu_pkg::*;
(
  input  logic [31:0] raw32,
  input  logic [2:0]  funct3,
  output logic [31:0] ext32
);
  // pick the extension for byte/half loads; words pass through
  always_comb
    ext32 = funct3 == F3_B  ? {{24{raw32[7]}}, raw32[7:0]} :
            funct3 == F3_H  ? {{16{raw32[15]}}, raw32[15:0]} :
            funct3 == F3_BU ? {24'b0, raw32[7:0]} :
            funct3 == F3_HU ? {16'b0, raw32[15:0]} : raw32;
endmodule

// File: rtl/load_store_unit.sv
// load_store_unit: splits RV32I loads/stores into byte accesses on a byte-wide data memory
module load_store_unit
  import lsu_pkg::*;
#(
  parameter logic [2:0] BYTE_FUNCT3 = 3'b000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        mem_write,
  output logic        mem_read,
  output logic [2:0]  mem_funct3,
  input  logic [31:0] mem_rdata
);
  state_t state, state_next;
  logic [31:0] addr, wdata, asm, asm_next, ext;
  logic [2:0]  funct3, n;
  logic [1:0]  k;
  logic        we, err, last, req_bad, unused_rdata;
  assign req_bad = req_funct3[1:0] == 2'b11 || req_funct3 == 3'b110 || (req_we && req_funct3[2]) ||
                   (req_funct3[1:0] == 2'b01 && req_addr[0]) ||
                   (req_funct3[1:0] == 2'b10 && req_addr[1:0] != 2'b00);
  assign n            = byte_count(funct3);
  assign last         = {1'b0, k} == n - 3'd1;
  assign req_ready    = state == IDLE;
  assign resp_valid   = state == DONE;
  assign resp_err     = resp_valid && err;
  assign mem_write    = state == ST_BYTE && we;
  assign mem_read     = state == LD_ISSUE && !we;
  assign mem_addr     = (state == ST_BYTE || state == LD_ISSUE) ? addr + {30'b0, k} : '0;
  assign mem_wdata    = state == ST_BYTE ? {24'b0, wdata[{k, 3'b000} +: 8]} : '0;
  assign mem_funct3   = BYTE_FUNCT3;
  assign unused_rdata = ^mem_rdata[31:8];
  lsu_load_extend u_extend (
    .raw32  (asm_next),
    .funct3 (funct3),
    .ext32  (ext)
  );
  // merge the byte arriving from memory into its little-endian lane
  always_comb begin
    asm_next = asm;
    asm_next[{k, 3'b000} +: 8] = mem_rdata[7:0];
  end
  // state register
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else state <= state_next;
  end
  // next-state: bad requests skip straight to DONE, others walk bytes 0..n-1
  always_comb begin
    state_next = state;
    case (state)
      IDLE:     if (req_valid) state_next = req_bad ? DONE : req_we ? ST_BYTE : LD_ISSUE;
      ST_BYTE:  state_next = last ? DONE : ST_BYTE;
      LD_ISSUE: state_next = LD_CAP;
      LD_CAP:   state_next = last ? DONE : LD_ISSUE;
      DONE:     state_next = IDLE;
      default:  state_next = IDLE;
    endcase
  end
  // latch the request, step the byte index and assemble/publish load data
  always_ff @(posedge clk) begin
    if (reset) begin
      addr <= '0;
      wdata <= '0;
      we <= 1'b0;
      funct3 <= '0;
      k <= '0;
      err <= 1'b0;
      asm <= '0;
      resp_rdata <= '0;
    end else begin
      if (req_valid && req_ready) begin
        addr <= req_addr;
        wdata <= req_wdata;
        we <= req_we;
        funct3 <= req_funct3;
        k <= '0;
        err <= req_bad;
        asm <= '0;
      end
      if (state == ST_BYTE && !last) k <= k + 2'd1;
      if (state == LD_CAP) begin
        asm <= asm_next;
        if (last) resp_rdata <= ext;
        else k <= k + 2'd1;
      end
    end
  end
endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: randomized and directed checks of load_store_unit against a transaction-level model
module tb_load_store_unit;
  localparam logic [2:0] TB_F3 = 3'b000;
  logic        clk = 1'b0, reset = 1'b1, req_valid = 1'b0, req_we = 1'b0;
  logic [2:0]  req_funct3 = 3'b000;
  logic [31:0] req_addr = '0, req_wdata = '0, mem_rdata = '0;
  logic        req_ready, resp_valid, resp_err, mem_write, mem_read;
  logic [31:0] resp_rdata, mem_addr, mem_wdata;
  logic [2:0]  mem_funct3;

  load_store_unit #(.BYTE_FUNCT3(TB_F3)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata), .resp_valid(resp_valid),
    .resp_rdata(resp_rdata), .resp_err(resp_err), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_write(mem_write), .mem_read(mem_read), .mem_funct3(mem_funct3), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // byte memory seen by the DUT; read data is noise unless a read was strobed
  logic [7:0] env_mem [256] = '{default: 8'h00};
  logic [7:0] ref_mem [256] = '{default: 8'h00};
  int cyc = 0;
  always @(posedge clk) begin
    if (mem_write) env_mem[mem_addr[7:0]] <= mem_wdata[7:0];
    mem_rdata <= mem_read ? {{24{env_mem[mem_addr[7:0]][7]}}, env_mem[mem_addr[7:0]]} : $urandom;
    cyc <= cyc + 1;
  end

  // transaction model: what the current request must do and when
  int          acc_cyc = -10, busy_until = -10, ex_n = 1;
  logic        ex_err = 0, ex_ld = 0, ex_we = 0, lit_en = 0, lit_err = 0;
  logic [31:0] ex_rdata = 0, ex_addr = 0, ex_wdata = 0, lit_rdata = 0;
  bit          fin = 0;

  function automatic int width_of(input logic [2:0] f);
    return f[1:0] == 2'b00 ? 1 : f[1:0] == 2'b01 ? 2 : 4;
  endfunction

  function automatic bit is_bad(input logic we, input logic [2:0] f, input logic [31:0] a);
    if (f == 3'b011 || f == 3'b110 || f == 3'b111) return 1;
    if (we && f[2]) return 1;
    if (width_of(f) == 2 && a % 2 != 0) return 1;
    if (width_of(f) == 4 && a % 4 != 0) return 1;
    return 0;
  endfunction

  function automatic logic [31:0] model_load(input logic [2:0] f, input logic [31:0] a);
    logic [31:0] v;
    logic [7:0]  idx;
    v = 0;
    for (int i = 0; i < width_of(f); i++) begin
      idx = a[7:0] + 8'(i);
      v = v | (32'(ref_mem[idx]) << (8 * i));
    end
    if (f == 3'b000 && v >= 32'h80) v = v + 32'hFFFFFF00;
    if (f == 3'b001 && v >= 32'h8000) v = v + 32'hFFFF0000;
    return v;
  endfunction

  task automatic issue(input logic we, input logic [2:0] f, input logic [31:0] a, input logic [31:0] wd,
                       input bit drop, input bit le, input logic [31:0] lr, input logic lerr);
    logic [7:0] idx;
    while (cyc <= busy_until) begin @(posedge clk); #2; end
    req_valid = 1; req_we = we; req_funct3 = f; req_addr = a; req_wdata = wd;
    @(posedge clk); #2;
    if (drop) req_valid = 0;
    acc_cyc = cyc;
    ex_err = is_bad(we, f, a);
    ex_n = width_of(f);
    ex_we = we; ex_addr = a; ex_wdata = wd;
    ex_ld = !we && !ex_err;
    busy_until = cyc + (ex_err ? 0 : we ? ex_n : 2 * ex_n);
    if (ex_ld) ex_rdata = model_load(f, a);
    if (we && !ex_err)
      for (int i = 0; i < ex_n; i++) begin
        idx = a[7:0] + 8'(i);
        ref_mem[idx] = 8'(wd >> (8 * i));
      end
    lit_en = le; lit_rdata = lr; lit_err = lerr;
  endtask

  // compare process
  int          n_cmp = 0, n_bad = 0;
  logic        was_reset = 1;
  logic [31:0] model_rdata = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    int off;
    logic active, dn, ew, er;
    logic [31:0] ea;
    if (fin) begin
      for (int i = 0; i < 256; i++) chk("mem_byte", 32'(env_mem[i]), 32'(ref_mem[i]));
      chk("lit_mem_10", 32'(env_mem[8'h10]), 32'hBB);
      chk("lit_mem_11", 32'(env_mem[8'h11]), 32'hAA);
      chk("lit_mem_12", 32'(env_mem[8'h12]), 32'h99);
      chk("lit_mem_13", 32'(env_mem[8'h13]), 32'h88);
      chk("lit_mem_30", 32'(env_mem[8'h30]), 32'h5A);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
    end else if (was_reset) begin
      model_rdata = 0;
      chk("rst_req_ready", 32'(req_ready), 1);
      chk("rst_resp_valid", 32'(resp_valid), 0);
      chk("rst_resp_err", 32'(resp_err), 0);
      chk("rst_resp_rdata", resp_rdata, 0);
      chk("rst_mem_read", 32'(mem_read), 0);
      chk("rst_mem_write", 32'(mem_write), 0);
      chk("rst_mem_addr", mem_addr, 0);
      chk("rst_mem_wdata", mem_wdata, 0);
    end else begin
      active = cyc >= acc_cyc && cyc <= busy_until;
      dn = active && cyc == busy_until;
      off = cyc - acc_cyc;
      ew = active && !ex_err && ex_we && off < ex_n;
      er = active && !ex_err && !ex_we && off < 2 * ex_n && off % 2 == 0;
      ea = ex_addr + 32'(ex_we ? off : off / 2);
      if (dn && ex_ld) model_rdata = ex_rdata;
      chk("req_ready", 32'(req_ready), 32'(!active));
      chk("resp_valid", 32'(resp_valid), 32'(dn));
      if (dn) chk("resp_err", 32'(resp_err), 32'(ex_err));
      if (dn && lit_en) begin
        chk("lit_rdata", resp_rdata, lit_rdata);
        chk("lit_err", 32'(resp_err), 32'(lit_err));
      end
      chk("resp_rdata", resp_rdata, model_rdata);
      chk("mem_write", 32'(mem_write), 32'(ew));
      chk("mem_read", 32'(mem_read), 32'(er));
      if (ew) begin
        chk("mem_addr_wr", mem_addr, ea);
        chk("mem_wdata", mem_wdata, (ex_wdata >> (8 * off)) & 32'hFF);
      end
      if (er) chk("mem_addr_rd", mem_addr, ea);
      chk("mem_funct3", 32'(mem_funct3), 32'(TB_F3));
    end
    was_reset = reset;
  end

  // stimulus: directed scenarios, then random traffic
  initial begin
    @(posedge clk); @(posedge clk); #2;
    reset = 0;
    issue(1, 3'b010, 32'h10, 32'h8899AABB, 1, 1, 32'h0, 0);
    issue(0, 3'b010, 32'h10, 32'h0, 1, 1, 32'h8899AABB, 0);
    issue(0, 3'b001, 32'h12, 32'h0, 1, 1, 32'hFFFF8899, 0);
    issue(0, 3'b101, 32'h12, 32'h0, 1, 1, 32'h00008899, 0);
    issue(0, 3'b000, 32'h11, 32'h0, 1, 1, 32'hFFFFFFAA, 0);
    issue(0, 3'b100, 32'h13, 32'h0, 1, 1, 32'h00000088, 0);
    issue(1, 3'b001, 32'h21, 32'hDEADBEEF, 1, 1, 32'h00000088, 1);
    issue(0, 3'b010, 32'h22, 32'h0, 1, 1, 32'h00000088, 1);
    issue(0, 3'b011, 32'h10, 32'h0, 1, 1, 32'h00000088, 1);
    issue(0, 3'b010, 32'h10, 32'h0, 1, 0, 32'h0, 0);
    repeat (3) begin @(posedge clk); #2; end
    reset = 1;
    @(posedge clk); #2;
    reset = 0;
    busy_until = cyc - 1;
    issue(1, 3'b000, 32'h30, 32'h1234565A, 1, 1, 32'h0, 0);
    issue(1, 3'b010, 32'h34, 32'h11223344, 0, 1, 32'h0, 0);
    issue(0, 3'b100, 32'h30, 32'h0, 1, 1, 32'h0000005A, 0);
    for (int i = 0; i < 300; i++) begin
      logic we;
      logic [2:0] f;
      logic [31:0] a;
      we = 1'($urandom_range(0, 1));
      f = 3'($urandom_range(0, 7));
      a = $urandom;
      a[7:0] = 8'(8'h40 + 8'($urandom_range(0, 191)));
      if ($urandom_range(0, 3) != 0) begin
        if (f[1:0] == 2'b10) a[1:0] = 2'b00;
        else if (f[1:0] == 2'b01) a[0] = 1'b0;
      end
      issue(we, f, a, $urandom, 1, 0, 32'h0, 0);
    end
    while (cyc <= busy_until) begin @(posedge clk); #2; end
    fin = 1;
  end
endmodule
